// File: rtl/vga_pkg.sv
// Shared types, colour constants and 640x480 timing constants for the VGA pattern generator.
// The optional grid overlay in vga_pattern_gen is enabled by defining VGA_PATTERN_GRID_EN.
package vga_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        BARS    = 2'd1,
        CHECKER = 2'd2,
        BOX     = 2'd3
    } pattern_e;

    typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dx_e;
    typedef enum logic {DOWN = 1'b0, UP = 1'b1} dy_e;

    typedef struct packed {
        dx_e dx;
        dy_e dy;
    } box_dir_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK   = 12'h000;
    localparam rgb_t COL_WHITE   = 12'hFFF;
    localparam rgb_t COL_YELLOW  = 12'hFF0;
    localparam rgb_t COL_CYAN    = 12'h0FF;
    localparam rgb_t COL_GREEN   = 12'h0F0;
    localparam rgb_t COL_MAGENTA = 12'hF0F;
    localparam rgb_t COL_RED     = 12'hF00;
    localparam rgb_t COL_BLUE    = 12'h00F;

    localparam int unsigned TIMING_H_VISIBLE = 640;
    localparam int unsigned TIMING_H_FRONT   = 16;
    localparam int unsigned TIMING_H_SYNC    = 96;
    localparam int unsigned TIMING_H_BACK    = 48;
    localparam int unsigned TIMING_H_TOTAL   = 800;
    localparam int unsigned TIMING_V_VISIBLE = 480;
    localparam int unsigned TIMING_V_FRONT   = 10;
    localparam int unsigned TIMING_V_SYNC    = 2;
    localparam int unsigned TIMING_V_BACK    = 33;
    localparam int unsigned TIMING_V_TOTAL   = 525;

    // One bounce-axis step; returns {moving_back, new_pos}. 12-bit math avoids overflow.
    function automatic logic [11:0] axis_step(input logic [10:0] pos, input logic back,
                                              input logic [10:0] max, input logic [10:0] step);
        logic [11:0] p;
        logic [11:0] m;
        logic [11:0] s;
        logic [11:0] r;
        p = {1'b0, pos};
        m = {1'b0, max};
        s = {1'b0, step};
        if (!back) begin
            if (p + s >= m) r = {1'b1, m[10:0]};
            else            r = {1'b0, 11'(p + s)};
        end else begin
            if (p <= s) r = {1'b0, 11'd0};
            else        r = {1'b1, 11'(p - s)};
        end
        return r;
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        unique case (idx)
            3'd0: c = COL_WHITE;
            3'd1: c = COL_YELLOW;
            3'd2: c = COL_CYAN;
            3'd3: c = COL_GREEN;
            3'd4: c = COL_MAGENTA;
            3'd5: c = COL_RED;
            3'd6: c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position and direction, advanced once per frame start.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = TIMING_H_VISIBLE,
    parameter int unsigned V_VISIBLE = TIMING_V_VISIBLE,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned BOX_STEP  = 2
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        frame_start,
    output logic [10:0] box_x,
    output logic [10:0] box_y
);

    localparam logic [10:0] X_MAX = 11'(H_VISIBLE - BOX_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - BOX_SIZE);
    localparam logic [10:0] STEP  = 11'(BOX_STEP);

    logic [10:0] x_q, x_d, y_q, y_d;
    box_dir_t    dir_q, dir_d;
    logic [11:0] x_nxt, y_nxt;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dir_q <= '{dx: RIGHT, dy: DOWN};
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dir_q <= dir_d;
        end
    end

    always_comb begin
        x_nxt = axis_step(x_q, dir_q.dx == LEFT, X_MAX, STEP);
        y_nxt = axis_step(y_q, dir_q.dy == UP, Y_MAX, STEP);
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        if (frame_start) begin
            x_d      = x_nxt[10:0];
            y_d      = y_nxt[10:0];
            dir_d.dx = x_nxt[11] ? LEFT : RIGHT;
            dir_d.dy = y_nxt[11] ? UP : DOWN;
        end
    end

    always_comb begin
        box_x = x_q;
        box_y = y_q;
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: two-stage pipeline from timing inputs to registered RGB and syncs.
// Define VGA_PATTERN_GRID_EN to overlay a white 64-pixel grid on every pattern.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = TIMING_H_VISIBLE,
    parameter int unsigned V_VISIBLE   = TIMING_V_VISIBLE,
    parameter int unsigned BOX_SIZE    = 32,
    parameter int unsigned BOX_STEP    = 2,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_active,
    input  logic [10:0] in_x,
    input  logic [10:0] in_y,
    input  logic [1:0]  pattern_sel,
    output logic        vga_horizontal_sync,
    output logic        vga_vertical_sync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic [7:0]  frame_count
);

    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic        vsync_q;
    logic        vsync_seen_q;
    logic        frame_start;
    pattern_e    pattern_q;
    logic [10:0] box_x, box_y;

    logic        s1_hsync, s1_vsync, s1_active;
    logic [10:0] s1_x, s1_y;
    logic [2:0]  bar_idx;
    logic        in_box;
    rgb_t        pix_rgb;

    // vsync_seen_q blocks a false edge when reset releases while vsync is already active.
    assign frame_start = vsync_seen_q && (in_vsync == SYNC_ACTIVE) && (vsync_q != SYNC_ACTIVE);

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vsync_q      <= ~SYNC_ACTIVE;
            vsync_seen_q <= 1'b0;
            pattern_q    <= SOLID;
            frame_count  <= '0;
        end else begin
            vsync_q      <= in_vsync;
            vsync_seen_q <= 1'b1;
            if (frame_start) begin
                pattern_q   <= pattern_e'(pattern_sel);
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    vga_box_mover #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .BOX_SIZE  (BOX_SIZE),
        .BOX_STEP  (BOX_STEP)
    ) u_box_mover (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .frame_start (frame_start),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s1_hsync  <= ~SYNC_ACTIVE;
            s1_vsync  <= ~SYNC_ACTIVE;
            s1_active <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
        end else begin
            s1_hsync  <= in_hsync;
            s1_vsync  <= in_vsync;
            s1_active <= in_active;
            s1_x      <= in_x;
            s1_y      <= in_y;
        end
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (s1_x >= 11'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    always_comb begin
        in_box = ({1'b0, s1_x} >= {1'b0, box_x}) &&
                 ({1'b0, s1_x} < ({1'b0, box_x} + 12'(BOX_SIZE))) &&
                 ({1'b0, s1_y} >= {1'b0, box_y}) &&
                 ({1'b0, s1_y} < ({1'b0, box_y} + 12'(BOX_SIZE)));
    end

    always_comb begin
        pix_rgb = COL_BLACK;
        if (s1_active) begin
            unique case (pattern_q)
                SOLID:   pix_rgb = COL_MAGENTA;
                BARS:    pix_rgb = bar_colour(bar_idx);
                CHECKER: pix_rgb = (s1_x[5] ^ s1_y[5]) ? COL_WHITE : COL_BLACK;
                BOX:     pix_rgb = in_box ? COL_WHITE : COL_BLUE;
                default: pix_rgb = COL_BLACK;
            endcase
`ifdef VGA_PATTERN_GRID_EN
            if (s1_x[5:0] == 6'd0 || s1_y[5:0] == 6'd0) pix_rgb = COL_WHITE;
`endif
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vga_horizontal_sync <= ~SYNC_ACTIVE;
            vga_vertical_sync   <= ~SYNC_ACTIVE;
            vga_r               <= '0;
            vga_g               <= '0;
            vga_b               <= '0;
        end else begin
            vga_horizontal_sync <= s1_hsync;
            vga_vertical_sync   <= s1_vsync;
            vga_r               <= pix_rgb.r;
            vga_g               <= pix_rgb.g;
            vga_b               <= pix_rgb.b;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen against a frame-level behavioural model.
module tb_vga_pattern_gen;

    localparam int HV = 640;
    localparam int VV = 480;
    localparam int BS = 32;
    localparam int STEP = 2;
    localparam bit SA = 1'b0;
    localparam bit VA = SA;
    localparam bit VI = !SA;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        in_hsync, in_vsync, in_active;
    logic [10:0] in_x, in_y;
    logic [1:0]  pattern_sel;
    logic        vga_horizontal_sync, vga_vertical_sync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [7:0]  frame_count;

    always #5 clk_pixel = ~clk_pixel;

    vga_pattern_gen #(
        .H_VISIBLE   (HV),
        .V_VISIBLE   (VV),
        .BOX_SIZE    (BS),
        .BOX_STEP    (STEP),
        .SYNC_ACTIVE (SA)
    ) dut (
        .clk_pixel           (clk_pixel),
        .reset               (reset),
        .in_hsync            (in_hsync),
        .in_vsync            (in_vsync),
        .in_active           (in_active),
        .in_x                (in_x),
        .in_y                (in_y),
        .pattern_sel         (pattern_sel),
        .vga_horizontal_sync (vga_horizontal_sync),
        .vga_vertical_sync   (vga_vertical_sync),
        .vga_r               (vga_r),
        .vga_g               (vga_g),
        .vga_b               (vga_b),
        .frame_count         (frame_count)
    );

    typedef struct {
        string      tag;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t pipe[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state
    int m_pat, m_bx, m_by, m_fc, m_frames;
    bit m_xback, m_yback, m_prev_vs, m_prev_ok;

    logic [11:0] bars[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bounce(inout int p, inout bit back, input int lim);
        if (!back) begin
            if (p + STEP >= lim) begin p = lim; back = 1; end
            else p = p + STEP;
        end else begin
            if (p <= STEP) begin p = 0; back = 0; end
            else p = p - STEP;
        end
    endtask

    function automatic logic [11:0] model_rgb(int x, int y, bit act);
        if (!act) return 12'h000;
`ifdef VGA_PATTERN_GRID_EN
        if (x % 64 == 0 || y % 64 == 0) return 12'hFFF;
`endif
        case (m_pat)
            0: return 12'hF0F;
            1: return bars[x / (HV / 8)];
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: begin
                if (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS) return 12'hFFF;
                return 12'h00F;
            end
        endcase
    endfunction

    // Drive one cycle, update the model, advance a clock and compare the output two cycles old.
    task automatic apply(input bit rst, input bit hs, input bit vs, input bit act, input int x,
                         input int y, input int sel, input int ovr, input string tag);
        exp_t e, o;
        reset = rst; in_hsync = hs; in_vsync = vs; in_active = act;
        in_x = 11'(x); in_y = 11'(y); pattern_sel = 2'(sel);
        if (rst) begin
            m_pat = 0; m_bx = 0; m_by = 0; m_xback = 0; m_yback = 0; m_fc = 0; m_frames = 0;
            if (pipe.size() > 0) begin
                o = pipe.pop_back();
                o.rgb = 12'h000; o.hs = VI; o.vs = VI;
                pipe.push_back(o);
            end
        end else if (vs == VA && m_prev_ok && m_prev_vs == VI) begin
            m_pat = sel;
            bounce(m_bx, m_xback, HV - BS);
            bounce(m_by, m_yback, VV - BS);
            m_fc = (m_fc + 1) % 256;
            m_frames++;
        end
        m_prev_vs = vs;
        m_prev_ok = !rst;
        e.tag = tag;
        e.hs  = rst ? VI : hs;
        e.vs  = rst ? VI : vs;
        e.rgb = rst ? 12'h000 : (ovr >= 0 ? 12'(ovr) : model_rgb(x, y, act));
        pipe.push_back(e);
        @(posedge clk_pixel);
        #1;
        if (pipe.size() == 2) begin
            o = pipe.pop_front();
            check({o.tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(o.rgb));
            check({o.tag, "_hs"}, 32'(vga_horizontal_sync), 32'(o.hs));
            check({o.tag, "_vs"}, 32'(vga_vertical_sync), 32'(o.vs));
        end
        check("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic idle(input int sel);
        apply(0, 1'($urandom_range(0, 1)), VI, 0, 0, 0, sel, -1, "idle");
    endtask

    task automatic pixel(input int x, input int y, input int sel, input int ovr, input string tag);
        apply(0, 1'($urandom_range(0, 1)), VI, 1, x, y, sel, ovr, tag);
    endtask

    task automatic frame_pulse(input int sel);
        apply(0, 1'($urandom_range(0, 1)), VI, 0, 0, 0, sel, -1, "pre_vs");
        apply(0, 1'($urandom_range(0, 1)), VA, 0, 0, 0, sel, -1, "vs0");
        apply(0, 1'($urandom_range(0, 1)), VA, 0, 0, 0, sel, -1, "vs1");
    endtask

    task automatic rand_pixel(input int sel);
        int x, y;
        bit act;
        act = ($urandom_range(0, 7) != 0);
        if (m_pat == 3 && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
                0: x = m_bx - 1;
                1: x = m_bx;
                2: x = m_bx + BS - 1;
                default: x = m_bx + BS;
            endcase
            y = m_by + $urandom_range(0, BS);
            if (x < 0) x = 0;
            if (x > HV - 1) x = HV - 1;
            if (y > VV - 1) y = VV - 1;
        end else begin
            x = $urandom_range(0, HV - 1);
            y = $urandom_range(0, VV - 1);
        end
        apply(0, 1'($urandom_range(0, 1)), VI, act, x, y, sel, -1, "rand");
    endtask

    initial begin
        int fc_before, sel;
        bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
        bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
        m_prev_ok = 0; m_prev_vs = VI;

        repeat (3) apply(1, VI, VI, 0, 0, 0, 0, -1, "reset");
        check("rst_fc", 32'(frame_count), 0);
        check("rst_hs", 32'(vga_horizontal_sync), 1);
        check("rst_vs", 32'(vga_vertical_sync), 1);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        repeat (2) idle(0);

        // Colour bars at fixed coordinates
        frame_pulse(1);
        pixel(85, 10, 1, 12'hFF0, "bars85");
        pixel(639, 10, 1, 12'h000, "bars639");
        repeat (6) rand_pixel(1);

        // Pattern change ignored until next frame start
        frame_pulse(0);
        pixel(100, 100, 0, 12'hF0F, "solid_pre");
        pixel(100, 100, 2, 12'hF0F, "sel_hold");
        pixel(200, 300, 2, 12'hF0F, "sel_hold2");
        frame_pulse(2);
        pixel(32, 0, 2, 12'hFFF, "chk32");
        repeat (6) rand_pixel(2);

        // Grid overlay on the solid pattern
        frame_pulse(0);
`ifdef VGA_PATTERN_GRID_EN
        pixel(64, 10, 0, 12'hFFF, "grid64");
`else
        pixel(64, 10, 0, 12'hF0F, "grid64");
`endif
        pixel(65, 10, 0, 12'hF0F, "grid65");

        // vsync held active for a whole line counts once
        fc_before = m_fc;
        apply(0, 1, VI, 0, 0, 0, 3, -1, "pre_line");
        repeat (800) apply(0, 1'($urandom_range(0, 1)), VA, 0, 0, 0, 3, -1, "vs_line");
        idle(3);
        check("vs_line_once", 32'(frame_count), 32'((fc_before + 1) % 256));

        // Random frames; force the box pattern around the right-edge bounce
        while (m_frames < 320) begin
            if (m_frames >= 294 && m_frames <= 315) sel = 3;
            else sel = $urandom_range(0, 3);
            frame_pulse(sel);
            if (m_frames == 300) check("fc300", 32'(frame_count), 44);
            repeat (4) rand_pixel($urandom_range(0, 3));
        end

        // Reset released while vsync already active must not count a frame
        repeat (2) apply(1, 1, VA, 0, 0, 0, 2, -1, "rst_vs_act");
        repeat (5) apply(0, 1, VA, 0, 0, 0, 2, -1, "post_rst_vs");
        check("no_false_fs", 32'(frame_count), 0);
        frame_pulse(2);
        check("first_true_fs", 32'(frame_count), 1);

        // Reset coinciding with a frame start
        repeat (3) frame_pulse(3);
        apply(0, 1, VI, 1, 5, 5, 3, -1, "pre_coinc");
        apply(1, 0, VA, 1, 5, 5, 3, -1, "rst_coinc");
        check("coinc_fc", 32'(frame_count), 0);
        check("coinc_hs", 32'(vga_horizontal_sync), 1);
        check("coinc_vs", 32'(vga_vertical_sync), 1);
        check("coinc_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        idle(3);
        frame_pulse(3);
        pixel(2, 2, 3, 12'hFFF, "box22");
        pixel(1, 1, 3, 12'h00F, "box11");
        pixel(33, 10, 3, 12'hFFF, "box33");
        pixel(34, 10, 3, 12'h00F, "box34");
        repeat (2) idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
